// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB write-back and decode read-port bundle for wb_regfile
interface wb_regfile_if #(
    parameter int CNT_W = 32
);
    logic             RegWrite_i;
    logic             MemtoReg_i;
    logic [31:0]      ReadData_i;
    logic [31:0]      ALUdata_i;
    logic [4:0]       RDaddr_i;
    logic [4:0]       RSaddr_i;
    logic [4:0]       RTaddr_i;
    logic [31:0]      RSdata_o;
    logic [31:0]      RTdata_o;
    logic [31:0]      WBdata_o;
    logic [CNT_W-1:0] WBcount_o;
    modport master (
        output RegWrite_i, MemtoReg_i, ReadData_i, ALUdata_i, RDaddr_i, RSaddr_i, RTaddr_i,
        input  RSdata_o, RTdata_o, WBdata_o, WBcount_o
    );
    modport slave (
        input  RegWrite_i, MemtoReg_i, ReadData_i, ALUdata_i, RDaddr_i, RSaddr_i, RTaddr_i,
        output RSdata_o, RTdata_o, WBdata_o, WBcount_o
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 32x32 register file and retired-write counter; WB_REGFILE_BYPASS_EN enables write-through reads
module wb_regfile #(
    parameter int CNT_W = 32
) (
    input logic         clk_i,
    input logic         rst_i,
    wb_regfile_if.slave bus
);
    logic [31:0]      regs [32];
    logic [CNT_W-1:0] cnt;
    logic [31:0]      wb;
    logic             we;
    logic             byp_s;
    logic             byp_t;

    assign wb            = bus.MemtoReg_i ? bus.ReadData_i : bus.ALUdata_i;
    assign we            = bus.RegWrite_i && (bus.RDaddr_i != 5'd0);
    assign bus.WBdata_o  = wb;
    assign bus.WBcount_o = cnt;

`ifdef WB_REGFILE_BYPASS_EN
    assign byp_s = we && (bus.RSaddr_i == bus.RDaddr_i);
    assign byp_t = we && (bus.RTaddr_i == bus.RDaddr_i);
`else
    assign byp_s = 1'b0;
    assign byp_t = 1'b0;
`endif

    // commit effective writes and count them; register 0 is never written so it stays zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            cnt <= '0;
        end else if (we) begin
            regs[bus.RDaddr_i] <= wb;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // combinational read ports, optionally forwarding the committing value
    always_comb begin
        bus.RSdata_o = (bus.RSaddr_i == 5'd0) ? 32'd0 : byp_s ? wb : regs[bus.RSaddr_i];
        bus.RTdata_o = (bus.RTaddr_i == 5'd0) ? 32'd0 : byp_t ? wb : regs[bus.RTaddr_i];
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed test of wb_regfile against a register-array model, plus a 4-bit counter instance for wrap
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    wb_regfile_if #(.CNT_W(32)) b  ();
    wb_regfile_if #(.CNT_W(4))  b4 ();

    assign b4.RegWrite_i = b.RegWrite_i;
    assign b4.MemtoReg_i = b.MemtoReg_i;
    assign b4.ReadData_i = b.ReadData_i;
    assign b4.ALUdata_i  = b.ALUdata_i;
    assign b4.RDaddr_i   = b.RDaddr_i;
    assign b4.RSaddr_i   = b.RSaddr_i;
    assign b4.RTaddr_i   = b.RTaddr_i;

    wb_regfile #(.CNT_W(32)) dut  (.clk_i(clk), .rst_i(rst), .bus(b));
    wb_regfile #(.CNT_W(4))  dut4 (.clk_i(clk), .rst_i(rst), .bus(b4));

    logic [31:0] m [32];
    int unsigned m_cnt;

    function automatic logic [31:0] sel();
        return b.MemtoReg_i ? b.ReadData_i : b.ALUdata_i;
    endfunction

    function automatic logic [31:0] rd(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (BYP && b.RegWrite_i && b.RDaddr_i == a) return sel();
        return m[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m[i] = 32'd0;
            m_cnt = 0;
        end else if (b.RegWrite_i && b.RDaddr_i != 0) begin
            m[b.RDaddr_i] = sel();
            m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        check("cmp_rs", b.RSdata_o, rd(b.RSaddr_i));
        check("cmp_rt", b.RTdata_o, rd(b.RTaddr_i));
        check("cmp_wb", b.WBdata_o, sel());
        check("cmp_cnt", b.WBcount_o, m_cnt);
        check("cmp_cnt4", {28'd0, b4.WBcount_o}, m_cnt % 16);
        check("cmp_rs4", b4.RSdata_o, rd(b.RSaddr_i));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic we, input logic mtr, input logic [31:0] rdata,
                         input logic [31:0] alu, input logic [4:0] rda);
        b.RegWrite_i = we;
        b.MemtoReg_i = mtr;
        b.ReadData_i = rdata;
        b.ALUdata_i  = alu;
        b.RDaddr_i   = rda;
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        b.RSaddr_i = 5'd0;
        b.RTaddr_i = 5'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        // reset clears registers and counter immediately
        drive(1'b1, 1'b0, 32'd0, 32'h1234, 5'd5);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        b.RSaddr_i = 5'd5;
        #1;
        check("reg5_written", b.RSdata_o, 32'h1234);
        check("cnt_one", b.WBcount_o, 32'd1);
        rst = 1'b1;
        #1;
        check("reset_reg5", b.RSdata_o, 32'd0);
        check("reset_cnt", b.WBcount_o, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 32'h77, 5'd5);
        tick();
        #1;
        check("reset_blocks_write", b.RSdata_o, 32'd0);
        check("reset_blocks_cnt", b.WBcount_o, 32'd0);
        rst = 1'b0;
        // write-back mux and commit
        drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h11, 5'd3);
        #1;
        check("wb_mux_load", b.WBdata_o, 32'hDEADBEEF);
        tick();
        drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h11, 5'd4);
        #1;
        check("wb_mux_alu", b.WBdata_o, 32'h11);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        b.RSaddr_i = 5'd3;
        b.RTaddr_i = 5'd4;
        #1;
        check("reg3", b.RSdata_o, 32'hDEADBEEF);
        check("reg4", b.RTdata_o, 32'h11);
        check("cnt_two", b.WBcount_o, 32'd2);
        // register 0 guard
        drive(1'b1, 1'b0, 32'd0, 32'hFFFFFFFF, 5'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        b.RSaddr_i = 5'd0;
        #1;
        check("r0_zero", b.RSdata_o, 32'd0);
        check("r0_no_count", b.WBcount_o, 32'd2);
        // write disable
        drive(1'b1, 1'b0, 32'd0, 32'h55, 5'd7);
        tick();
        drive(1'b0, 1'b1, 32'hAAAA, 32'hAAAA, 5'd7);
        tick();
        b.RSaddr_i = 5'd7;
        #1;
        check("reg7_kept", b.RSdata_o, 32'h55);
        check("disable_cnt", b.WBcount_o, 32'd3);
        // same-cycle hazard
        drive(1'b1, 1'b0, 32'd0, 32'h1, 5'd9);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'h2, 5'd9);
        b.RSaddr_i = 5'd9;
        b.RTaddr_i = 5'd9;
        #1;
        check("hazard_rs_pre", b.RSdata_o, BYP ? 32'h2 : 32'h1);
        check("hazard_rt_pre", b.RTdata_o, BYP ? 32'h2 : 32'h1);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        #1;
        check("hazard_rs_post", b.RSdata_o, 32'h2);
        check("hazard_rt_post", b.RTdata_o, 32'h2);
        check("hazard_cnt", b.WBcount_o, 32'd5);
        // 4-bit counter wrap from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b0, 32'd0, 32'(i * 3), 5'((i % 31) + 1));
            tick();
            #1;
            check("wrap_cnt4", {28'd0, b4.WBcount_o}, 32'(i % 16));
        end
        check("wrap_cnt32", b.WBcount_o, 32'd16);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        b.RSaddr_i = 5'd16;
        b.RTaddr_i = 5'd2;
        #1;
        check("wrap_reg16", b.RSdata_o, 32'd45);
        check("wrap_reg2", b.RTdata_o, 32'd3);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects write-back data (load data or ALU result), commits it into a 32 x 32-bit register file, and serves the two decode-stage read ports. It exports the selected write-back value for the forwarding unit and keeps a retired-write counter for performance debug.

## Interface
Parameters:
- CNT_W, 32, width of retired-write counter

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- RegWrite_i  in  1  write enable from MEM/WB
- MemtoReg_i  in  1  1: write ReadData_i, 0: write ALUdata_i
- ReadData_i  in  32  load data from MEM/WB
- ALUdata_i  in  32  ALU result from MEM/WB
- RDaddr_i  in  5  destination register from MEM/WB
- RSaddr_i  in  5  read port A address (decode stage)
- RTaddr_i  in  5  read port B address (decode stage)
- RSdata_o  out  32  read port A data
- RTdata_o  out  32  read port B data
- WBdata_o  out  32  selected write-back data (to forwarding mux)
- WBcount_o  out  CNT_W  number of committed register writes

## Operation
- WBdata_o = MemtoReg_i ? ReadData_i : ALUdata_i; combinational, valid regardless of RegWrite_i.
- Effective write: we = RegWrite_i && (RDaddr_i != 0). On rising edge with we, reg[RDaddr_i] <= WBdata_o.
- Register 0 is hardwired zero: writes to it are discarded, reads return 0, never counted.
- Reads are combinational: RSdata_o = (RSaddr_i == 0) ? 0 : reg[RSaddr_i]; same for RTdata_o.
- Same-cycle write/read to the same nonzero register: see WB_BYPASS_EN.
- WBcount_o increments by 1 on every rising edge with we; wraps modulo 2^CNT_W (0xFFFFFFFF -> 0 for default).
- RegWrite_i = 0: no register or counter change, whatever the other inputs.

## Timing
- Reset (rst_i high, asynchronous): all 32 registers -> 0, WBcount_o -> 0 immediately, without clock. RSdata_o/RTdata_o therefore read 0 during and after reset until written.
- While rst_i is high, rising edges have no effect (no writes, no count). Deassertion takes effect at the next rising edge.
- Reset mid-write (rst_i asserted same cycle as we): reset wins; register and counter stay 0.
- Write latency: value visible on read ports one cycle after the write edge (same cycle with bypass).
- WBdata_o: zero-latency combinational from MemtoReg_i/ReadData_i/ALUdata_i.
- Both read ports may address the same register, or the written register, in the same cycle; both return the identical value.

## Configuration
- WB_REGFILE_BYPASS_EN defined: internal write-through bypass; if we and RSaddr_i == RDaddr_i (nonzero), RSdata_o = WBdata_o in that same cycle; likewise RTdata_o. Decode sees the committing value without an external forwarding path.
- Undefined: no bypass; read ports return the pre-edge register contents during the write cycle; the new value appears after the edge. Pipeline control must stall or forward externally.

## Test plan
- Reset: write reg 5 = 0x1234, assert rst_i between edges -> RSdata_o(RSaddr=5) = 0 and WBcount_o = 0 immediately, before next edge.
- Mux/write: RegWrite=1, MemtoReg=1, ReadData=0xDEADBEEF, ALUdata=0x11, RD=3, then MemtoReg=0 RD=4 -> reg3 = 0xDEADBEEF, reg4 = 0x11, WBcount_o = 2.
- r0 guard: RegWrite=1, RD=0, ALUdata=0xFFFFFFFF -> RSdata_o(RS=0) = 0, WBcount_o unchanged.
- Write disable: RegWrite=0, RD=7, ALUdata=0xAAAA -> reg7 keeps prior value, counter unchanged.
- Same-cycle hazard: reg9 = 0x1, then write reg9 = 0x2 with RS=RT=9 -> with WB_REGFILE_BYPASS_EN both ports show 0x2 pre-edge; without, 0x1 pre-edge and 0x2 post-edge.
- Counter wrap (CNT_W=4): 16 consecutive effective writes from reset -> WBcount_o sequence 1..15, then 0.
